calc_operand_loader: RTL and testbench
======================================

// Module: calc_operand_loader
// PURPOSE
//  Byte-stream front end for the calculator: collects a framed command (opcode, operand A,
//  operand B) from the I2C target's received-byte stream, packs the bytes into full-width
//  operands, and presents them to the calculator core with a valid/ready handshake.
//  Sits between the I2C target and the calculator in tt_um_bsrk_i2c_calc.
//  Also aborts partial frames and times out stalled ones.
// PARAMETERS
//  OPW      32   operand width in bits; multiple of 8; NB = OPW/8 bytes per operand
//  TIMEOUT  255  idle cycles allowed between bytes inside a frame before abort (>=1)
// PORTS
//  clk          in   1    clock; all logic on rising edge
//  rst          in   1    synchronous reset, active-high
//  frame_start  in   1    1-cycle pulse: I2C START/repeated START addressed to us
//  in_data      in   8    received byte
//  in_valid     in   1    in_data valid
//  in_ready     out  1    loader accepts byte; a transfer happens when in_valid & in_ready
//  op_a         out  OPW  first_input_number to calculator
//  op_b         out  OPW  second_input_number to calculator
//  op_sel       out  2    operation to calculator
//  op_valid     out  1    command held and stable
//  op_ready     in   1    calculator accepts; handshake = op_valid & op_ready
//  err_abort    out  1    1-cycle pulse: partial frame dropped by frame_start
//  err_timeout  out  1    1-cycle pulse: partial frame dropped by timeout
//  err_opcode   out  1    1-cycle pulse: opcode byte with bits[7:2] != 0
// BEHAVIOUR
//  Reset: state=IDLE; op_a=op_b=0; op_sel=0; op_valid=0; all err_*=0; in_ready=1.
//  Frame: 1 opcode byte (op=[1:0], [7:2] must be 0), then NB bytes A, then NB bytes B,
//   each MSB byte first. Total 1+2*NB bytes (9 at OPW=32).
//  States: IDLE -> OPC -> LDA -> LDB -> HOLD -> IDLE.
//   IDLE: in_ready=1; bytes consumed and discarded; frame_start -> OPC.
//   OPC: accepted byte with [7:2]==0 -> latch op into shadow, LDA; else err_opcode, IDLE.
//   LDA/LDB: byte counter 0..NB-1; shadow <= {shadow[OPW-9:0], in_data}; on count NB-1
//    move on (LDA->LDB, LDB->HOLD); counter clears on every state change.
//   HOLD: in_ready=0; op_valid=1; outputs stable; on handshake -> IDLE, op_valid=0 next cycle.
//  Commit: op_a/op_b/op_sel are loaded from the shadows only on the cycle the last B byte
//   is accepted; they retain their value after the handshake until the next commit.
//  Latency: op_valid rises the cycle after the last B byte is accepted.
//  frame_start in OPC/LDA/LDB: drop shadows, go to OPC; err_abort pulses if >=1 byte of
//   this frame was accepted. A byte accepted in the same cycle is ignored (frame_start wins).
//  frame_start in HOLD: ignored (held command protected); no error.
//  Timeout: idle counter runs in OPC/LDA/LDB, clears on any accepted byte or state change;
//   reaching TIMEOUT -> IDLE with err_timeout pulse. Counter saturates, never wraps.
//  err_* are mutually exclusive per cycle; priority abort > timeout > opcode.
//  rst mid-frame or in HOLD: immediate return to reset values; partial/held command lost.
// STRUCTURE
//  Shared package calc_pkg: operation encodings (shared with calculator), loader state
//   enum, OPC_RSVD_MASK = 8'hFC.
//  One sub-module: calc_byte_packer (OPW-wide MSB-first shift register + byte counter with
//   clear/shift/last outputs), instantiated for A and B; FSM and timer stay in this module.
// TESTING
//  1 frame_start; bytes 02,12,34,56,78,00,00,00,10; op_ready=1 -> op_sel=2,
//    op_a=32'h12345678, op_b=32'h10, op_valid high exactly 1 cycle.
//  2 Same frame with op_ready=0 for 20 cycles -> op_valid and outputs stable, in_ready=0;
//    frame_start pulses and bytes during HOLD have no effect.
//  3 frame_start, 4 bytes, frame_start, then full frame 01,... -> err_abort once; only the
//    second frame is committed.
//  4 frame_start, opcode 8'h05 -> err_opcode, state IDLE; next 8 bytes produce no op_valid.
//  5 frame_start, 3 bytes, stall TIMEOUT cycles -> err_timeout on the cycle the count reaches
//    TIMEOUT; stall of TIMEOUT-1 cycles then resume -> no error, normal commit.
//  6 rst asserted after byte 6 of a frame, then fresh frame -> outputs 0 during reset;
//    new command correct, no err_* pulses.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator encodings and operand-loader types
package calc_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } calc_op_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_LDA,
    ST_LDB,
    ST_HOLD
  } ld_state_e;
  localparam logic [7:0] OPC_RSVD_MASK = 8'hFC;
  function automatic logic opc_ok(input logic [7:0] b);
    return (b & OPC_RSVD_MASK) == 8'h00;
  endfunction
endpackage

// File: rtl/calc_byte_packer.sv
// calc_byte_packer: MSB-first byte shift register with per-operand byte counter
module calc_byte_packer #(
  parameter int OPW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           shift_i,
  input  logic [7:0]     data_i,
  output logic [OPW-1:0] data_o,
  output logic           last_o
);
  localparam int NB = OPW / 8;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  logic [OPW-1:0] data_q, data_d, shifted;
  logic [CW-1:0]  cnt_q, cnt_d;
  generate
    if (OPW > 8) begin : g_wide
      assign shifted = {data_q[OPW-9:0], data_i};
    end else begin : g_byte
      assign shifted = data_i;
    end
  endgenerate
  assign last_o = cnt_q == CW'(NB - 1);
  assign data_o = data_d;
  // next contents and byte position; data_o exposes the value including the byte shifted this cycle
  always_comb begin
    data_d = clr_i ? '0 : shift_i ? shifted : data_q;
    cnt_d  = clr_i ? '0 : shift_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  // shift register and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/calc_operand_loader.sv
// calc_operand_loader: frames opcode/A/B bytes into calculator operands with abort and timeout
module calc_operand_loader
  import calc_pkg::*;
#(
  parameter int OPW     = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_start,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [OPW-1:0] op_a,
  output logic [OPW-1:0] op_b,
  output logic [1:0]     op_sel,
  output logic           op_valid,
  input  logic           op_ready,
  output logic           err_abort,
  output logic           err_timeout,
  output logic           err_opcode
);
  localparam int TW = $clog2(TIMEOUT + 1);
  ld_state_e      state_q, state_d;
  logic [TW-1:0]  idle_q, idle_d;
  calc_op_e       opc_q, opc_d, op_sel_q;
  logic [OPW-1:0] op_a_q, op_b_q, a_data, b_data;
  logic           err_abort_q, err_timeout_q, err_opcode_q;
  logic           acc, active, restart, abort, tmo, opc_load, opc_bad;
  logic           shift_a, shift_b, a_last, b_last, commit, clr;
  assign in_ready    = state_q != ST_HOLD;
  assign op_valid    = state_q == ST_HOLD;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_sel      = op_sel_q;
  assign err_abort   = err_abort_q;
  assign err_timeout = err_timeout_q;
  assign err_opcode  = err_opcode_q;
  // frame events; a frame_start overrides any byte accepted in the same cycle
  always_comb begin
    acc      = in_valid & in_ready;
    active   = state_q == ST_OPC || state_q == ST_LDA || state_q == ST_LDB;
    restart  = frame_start & active;
    abort    = frame_start & (state_q == ST_LDA || state_q == ST_LDB);
    tmo      = active & ~frame_start & ~acc & (idle_q == TW'(TIMEOUT - 1));
    opc_load = state_q == ST_OPC && acc && !frame_start && opc_ok(in_data);
    opc_bad  = state_q == ST_OPC && acc && !frame_start && !opc_ok(in_data);
    shift_a  = state_q == ST_LDA && acc && !frame_start;
    shift_b  = state_q == ST_LDB && acc && !frame_start;
    commit   = shift_b & b_last;
    clr      = state_q == ST_IDLE || restart || tmo;
    opc_d    = clr ? OP_ADD : opc_load ? calc_op_e'(in_data[1:0]) : opc_q;
  end
  calc_byte_packer #(.OPW(OPW)) u_pack_a (
    .clk(clk), .rst(rst), .clr_i(clr), .shift_i(shift_a),
    .data_i(in_data), .data_o(a_data), .last_o(a_last)
  );
  calc_byte_packer #(.OPW(OPW)) u_pack_b (
    .clk(clk), .rst(rst), .clr_i(clr), .shift_i(shift_b),
    .data_i(in_data), .data_o(b_data), .last_o(b_last)
  );
  // next state: restart beats timeout beats byte progress
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = frame_start ? ST_OPC : ST_IDLE;
      ST_OPC:  state_d = restart ? ST_OPC : tmo ? ST_IDLE : opc_load ? ST_LDA : opc_bad ? ST_IDLE : ST_OPC;
      ST_LDA:  state_d = restart ? ST_OPC : tmo ? ST_IDLE : (shift_a && a_last) ? ST_LDB : ST_LDA;
      ST_LDB:  state_d = restart ? ST_OPC : tmo ? ST_IDLE : commit ? ST_HOLD : ST_LDB;
      ST_HOLD: state_d = op_ready ? ST_IDLE : ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end
  // inter-byte idle counter, saturating, cleared by any byte, restart or state change
  always_comb begin
    idle_d = (!active || acc || frame_start || state_d != state_q) ? '0 :
             (idle_q == TW'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
  end
  // state, shadows, committed command and one-cycle error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idle_q        <= '0;
      opc_q         <= OP_ADD;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_sel_q      <= OP_ADD;
      err_abort_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_opcode_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_q        <= idle_d;
      opc_q         <= opc_d;
      op_a_q        <= commit ? a_data : op_a_q;
      op_b_q        <= commit ? b_data : op_b_q;
      op_sel_q      <= commit ? opc_q : op_sel_q;
      err_abort_q   <= abort;
      err_timeout_q <= tmo & ~abort;
      err_opcode_q  <= opc_bad & ~abort & ~tmo;
    end
  end
endmodule

// File: tb/tb_calc_operand_loader.sv
// tb_calc_operand_loader: directed self-checking bench for the operand loader
module tb_calc_operand_loader;
  localparam int OPW = 32;
  localparam int TIMEOUT = 255;
  logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0, in_valid = 1'b0, op_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_ready, op_valid, err_abort, err_timeout, err_opcode;
  logic [OPW-1:0] op_a, op_b;
  logic [1:0] op_sel;
  int checks = 0, errors = 0;
  int n_abort = 0, n_tmo = 0, n_opc = 0, n_valid = 0, n_multi = 0;
  int ba, bt, bo, bv, bad;
  always #5 clk = ~clk;
  calc_operand_loader #(.OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
    .op_sel(op_sel), .op_valid(op_valid), .op_ready(op_ready),
    .err_abort(err_abort), .err_timeout(err_timeout), .err_opcode(err_opcode)
  );
  always @(negedge clk) begin
    if (!rst) begin
      n_abort += int'(err_abort);
      n_tmo   += int'(err_timeout);
      n_opc   += int'(err_opcode);
      n_valid += int'(op_valid);
      if (int'(err_abort) + int'(err_timeout) + int'(err_opcode) > 1) n_multi++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    in_data = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b);
    send(opc);
    for (int i = 3; i >= 0; i--) send(a[i*8+:8]);
    for (int i = 3; i >= 0; i--) send(b[i*8+:8]);
  endtask
  task automatic snap();
    ba = n_abort; bt = n_tmo; bo = n_opc; bv = n_valid;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_sel", op_sel, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_errs", {err_abort, err_timeout, err_opcode}, 0);
    rst = 1'b0;
    tick();
    // basic frame with immediate accept
    snap();
    pulse_fs();
    send_frame(8'h02, 32'h12345678, 32'h00000010);
    check("t1_valid", op_valid, 1);
    check("t1_in_ready", in_ready, 0);
    check("t1_op_sel", op_sel, 2);
    check("t1_op_a", op_a, 32'h12345678);
    check("t1_op_b", op_b, 32'h10);
    tick();
    check("t1_valid_drop", op_valid, 0);
    check("t1_op_a_keep", op_a, 32'h12345678);
    tick();
    check("t1_valid_cycles", n_valid - bv, 1);
    // held command survives back-pressure, frame_start and stray bytes
    op_ready = 1'b0;
    snap();
    pulse_fs();
    send_frame(8'h03, 32'hDEADBEEF, 32'hCAFEF00D);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      frame_start = (i == 5);
      if (i == 8) begin in_data = 8'h55; in_valid = 1'b1; end
      if (i == 10) in_valid = 1'b0;
      if (op_valid !== 1'b1 || in_ready !== 1'b0 || op_a !== 32'hDEADBEEF ||
          op_b !== 32'hCAFEF00D || op_sel !== 2'd3) bad++;
      tick();
    end
    frame_start = 1'b0;
    check("t2_hold_stable", bad, 0);
    check("t2_op_a", op_a, 32'hDEADBEEF);
    check("t2_op_b", op_b, 32'hCAFEF00D);
    check("t2_errs", (n_abort - ba) + (n_tmo - bt) + (n_opc - bo), 0);
    op_ready = 1'b1;
    tick();
    check("t2_release", op_valid, 0);
    check("t2_in_ready", in_ready, 1);
    // partial frame aborted by a new frame_start
    snap();
    pulse_fs();
    send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    pulse_fs();
    send_frame(8'h01, 32'h00000005, 32'h00000003);
    check("t3_op_sel", op_sel, 1);
    check("t3_op_a", op_a, 32'h5);
    check("t3_op_b", op_b, 32'h3);
    tick();
    tick();
    check("t3_abort_cnt", n_abort - ba, 1);
    check("t3_valid_cnt", n_valid - bv, 1);
    // reserved opcode bits reject the frame
    snap();
    pulse_fs();
    send(8'h05);
    check("t4_err_opcode", err_opcode, 1);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    tick();
    check("t4_opc_cnt", n_opc - bo, 1);
    check("t4_no_valid", n_valid - bv, 0);
    check("t4_op_a_keep", op_a, 32'h5);
    // stall of exactly TIMEOUT cycles times out
    snap();
    pulse_fs();
    send(8'h00); send(8'hAB); send(8'hCD);
    repeat (TIMEOUT - 1) tick();
    check("t5_no_tmo_yet", err_timeout, 0);
    tick();
    check("t5_err_timeout", err_timeout, 1);
    tick();
    check("t5_tmo_pulse", err_timeout, 0);
    check("t5_tmo_cnt", n_tmo - bt, 1);
    // stall of TIMEOUT-1 cycles then resume commits normally
    snap();
    pulse_fs();
    send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h07);
    repeat (TIMEOUT - 1) tick();
    send(8'h00); send(8'h00); send(8'h00); send(8'h09);
    check("t5_op_sel", op_sel, 0);
    check("t5_op_a", op_a, 32'h7);
    check("t5_op_b", op_b, 32'h9);
    check("t5_valid", op_valid, 1);
    tick();
    tick();
    check("t5_no_tmo", n_tmo - bt, 0);
    // reset mid-frame
    pulse_fs();
    send(8'h02); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    rst = 1'b1;
    tick();
    check("t6_rst_op_a", op_a, 0);
    check("t6_rst_op_b", op_b, 0);
    check("t6_rst_op_sel", op_sel, 0);
    check("t6_rst_valid", op_valid, 0);
    check("t6_rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    snap();
    pulse_fs();
    send_frame(8'h03, 32'h00000100, 32'h00000002);
    check("t6_op_sel", op_sel, 3);
    check("t6_op_a", op_a, 32'h100);
    check("t6_op_b", op_b, 32'h2);
    tick();
    tick();
    check("t6_errs", (n_abort - ba) + (n_tmo - bt) + (n_opc - bo), 0);
    check("err_exclusive", n_multi, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
